// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port arbiter/sequencer for the data RAM; DRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority on ties
module dram_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_P0_Req,
  input  logic [ADDR_WIDTH-1:0] i_P0_Addr,
  input  logic                  i_P0_WE,
  input  logic [3:0]            i_P0_ByteEn,
  input  logic [31:0]           i_P0_WD,
  output logic                  o_P0_Ack,
  output logic [31:0]           o_P0_RD,
  input  logic                  i_P1_Req,
  input  logic [ADDR_WIDTH-1:0] i_P1_Addr,
  input  logic                  i_P1_WE,
  input  logic [3:0]            i_P1_ByteEn,
  input  logic [31:0]           i_P1_WD,
  output logic                  o_P1_Ack,
  output logic [31:0]           o_P1_RD,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic                  o_Mem_WE,
  output logic [3:0]            o_Mem_ByteEn,
  output logic [31:0]           o_Mem_WD,
  input  logic [31:0]           i_Mem_RD
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, pick1;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d, wd_q, wd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic we_q, we_d;
  logic [3:0] be_q, be_d;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
  assign pick1 = i_P1_Req & (~i_P0_Req | ~last_q);
`else
  assign pick1 = i_P1_Req & ~i_P0_Req;
`endif
  assign o_P0_Ack     = ack0_q;
  assign o_P1_Ack     = ack1_q;
  assign o_P0_RD      = rd0_q;
  assign o_P1_RD      = rd1_q;
  assign o_Mem_Addr   = addr_q;
  assign o_Mem_WE     = we_q;
  assign o_Mem_ByteEn = be_q;
  assign o_Mem_WD     = wd_q;
  // next state: grant in IDLE, present controls for one ACCESS cycle, ack from DONE
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = '0;
    we_d    = 1'b0;
    be_d    = '0;
    wd_d    = '0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    case (state_q)
      IDLE: if (i_P0_Req | i_P1_Req) begin
        owner_d = pick1;
        last_d  = pick1;
        addr_d  = pick1 ? i_P1_Addr : i_P0_Addr;
        we_d    = pick1 ? i_P1_WE : i_P0_WE;
        be_d    = pick1 ? i_P1_ByteEn : i_P0_ByteEn;
        wd_d    = pick1 ? i_P1_WD : i_P0_WD;
        state_d = ACCESS;
      end
      ACCESS: begin
        state_d = we_q ? DONE : RDATA;
        ack0_d  = we_q & ~owner_q;
        ack1_d  = we_q & owner_q;
      end
      RDATA: begin
        rd0_d   = owner_q ? rd0_q : i_Mem_RD;
        rd1_d   = owner_q ? i_Mem_RD : rd1_q;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed self-checking bench for dram_arbiter with a byte-lane RAM model
module tb_dram_arbiter;
  logic i_Clk = 1'b0, i_Rst = 1'b1;
  logic i_P0_Req = 0, i_P0_WE = 0, i_P1_Req = 0, i_P1_WE = 0;
  logic [15:0] i_P0_Addr = 0, i_P1_Addr = 0;
  logic [3:0] i_P0_ByteEn = 0, i_P1_ByteEn = 0;
  logic [31:0] i_P0_WD = 0, i_P1_WD = 0;
  logic o_P0_Ack, o_P1_Ack, o_Mem_WE;
  logic [31:0] o_P0_RD, o_P1_RD, o_Mem_WD;
  logic [15:0] o_Mem_Addr;
  logic [3:0] o_Mem_ByteEn;
  logic [31:0] i_Mem_RD = 0;
  logic [31:0] ram [0:63];
  int total = 0, bad = 0;
  int lat;
  logic [31:0] rd;
  logic [15:0] a_seen;
  logic we_seen;
  logic [3:0] be_seen;
  dram_arbiter #(.ADDR_WIDTH(16)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_P0_Req(i_P0_Req), .i_P0_Addr(i_P0_Addr), .i_P0_WE(i_P0_WE), .i_P0_ByteEn(i_P0_ByteEn),
    .i_P0_WD(i_P0_WD), .o_P0_Ack(o_P0_Ack), .o_P0_RD(o_P0_RD),
    .i_P1_Req(i_P1_Req), .i_P1_Addr(i_P1_Addr), .i_P1_WE(i_P1_WE), .i_P1_ByteEn(i_P1_ByteEn),
    .i_P1_WD(i_P1_WD), .o_P1_Ack(o_P1_Ack), .o_P1_RD(o_P1_RD),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_WE(o_Mem_WE), .o_Mem_ByteEn(o_Mem_ByteEn),
    .o_Mem_WD(o_Mem_WD), .i_Mem_RD(i_Mem_RD)
  );
  always #5 i_Clk = ~i_Clk;
  initial begin
    for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + i;
    ram[2] <= 32'h6c6c6548;
    ram[3] <= 32'h6f57206f;
  end
  always @(posedge i_Clk) begin
    if (o_Mem_WE)
      for (int b = 0; b < 4; b++)
        if (o_Mem_ByteEn[b]) ram[o_Mem_Addr[5:0]][8*b+:8] <= o_Mem_WD[8*b+:8];
    i_Mem_RD <= ram[o_Mem_Addr[5:0]];
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xact(input bit p, input bit we, input logic [15:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    @(posedge i_Clk); #1;
    if (p) begin
      i_P1_Req = 1; i_P1_WE = we; i_P1_Addr = a; i_P1_ByteEn = be; i_P1_WD = wd;
    end else begin
      i_P0_Req = 1; i_P0_WE = we; i_P0_Addr = a; i_P0_ByteEn = be; i_P0_WD = wd;
    end
    lat = 0;
    @(negedge i_Clk);
    while (!(p ? o_P1_Ack : o_P0_Ack) && lat < 20) begin
      @(negedge i_Clk);
      lat++;
      if (lat == 1) begin
        a_seen = o_Mem_Addr; we_seen = o_Mem_WE; be_seen = o_Mem_ByteEn;
      end
    end
    rd = p ? o_P1_RD : o_P0_RD;
    @(posedge i_Clk); #1;
    i_P0_Req = 0; i_P1_Req = 0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, {o_P0_Ack, o_P1_Ack}, 0);
    check({tag, "_rd0"}, o_P0_RD, 0);
    check({tag, "_rd1"}, o_P1_RD, 0);
    check({tag, "_mem"}, {o_Mem_Addr, o_Mem_WE, o_Mem_ByteEn}, 0);
    check({tag, "_wd"}, o_Mem_WD, 0);
  endtask
  initial begin
    int n, seen1, both;
    logic [3:0] order;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    check_reset_outputs("reset");
    i_Rst = 0;
    xact(0, 0, 16'd2, 4'h0, 0);
    check("p0_rd_lat", lat, 3);
    check("p0_rd_addr", a_seen, 2);
    check("p0_rd_we", we_seen, 0);
    check("p0_rd_data", rd, 32'h6c6c6548);
    xact(1, 1, 16'd10, 4'hf, 32'hDEADBEEF);
    check("p1_wr_lat", lat, 2);
    check("p1_wr_ctl", {we_seen, be_seen, a_seen}, {1'b1, 4'hf, 16'd10});
    xact(1, 0, 16'd10, 4'h0, 0);
    check("p1_rd_lat", lat, 3);
    check("p1_rd_data", rd, 32'hDEADBEEF);
    xact(0, 1, 16'd10, 4'b0001, 32'h00000055);
    check("p0_wr_lat", lat, 2);
    xact(0, 0, 16'd10, 4'h0, 0);
    check("p0_merge_data", rd, 32'hDEADBE55);
    check("p1_rd_hold", o_P1_RD, 32'hDEADBEEF);
    xact(0, 1, 16'd3, 4'h0, 32'hFFFFFFFF);
    check("be0_wr_lat", lat, 2);
    check("be0_wr_be", {we_seen, be_seen}, {1'b1, 4'h0});
    xact(0, 0, 16'd3, 4'h0, 0);
    check("be0_rd_data", rd, 32'h6f57206f);
    @(posedge i_Clk); #1;
    i_P1_Req = 1; i_P1_WE = 0; i_P1_Addr = 16'd10;
    @(negedge i_Clk);
    @(negedge i_Clk);
    check("rst_access_addr", o_Mem_Addr, 10);
    i_Rst = 1; i_P1_Req = 0;
    @(negedge i_Clk);
    check_reset_outputs("rst_mid");
    i_Rst = 0;
    seen1 = 0;
    repeat (5) begin
      @(negedge i_Clk);
      if (o_P1_Ack) seen1++;
    end
    check("rst_no_p1_ack", seen1, 0);
    @(posedge i_Clk); #1;
    i_P0_Req = 1; i_P0_WE = 0; i_P0_Addr = 16'd2;
    i_P1_Req = 1; i_P1_WE = 0; i_P1_Addr = 16'd3;
    n = 0; both = 0; order = 0; lat = 0;
    while (n < 4 && lat < 60) begin
      @(negedge i_Clk);
      lat++;
      if (o_P0_Ack && o_P1_Ack) both++;
      if (o_P0_Ack || o_P1_Ack) begin
        order[n] = o_P1_Ack;
        n++;
      end
    end
    check("tie_count", n, 4);
    check("tie_first_lat", o_P0_RD, 32'h6c6c6548);
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    check("tie_order", order, 4'b1010);
`else
    check("tie_order", order, 4'b0000);
`endif
    @(posedge i_Clk); #1;
    i_P0_Req = 0;
    lat = 0;
    while (!o_P1_Ack && lat < 20) begin
      @(negedge i_Clk);
      lat++;
      if (o_P0_Ack) both++;
    end
    check("tie_p1_after_drop", o_P1_Ack, 1);
    check("tie_p1_data", o_P1_RD, 32'h6f57206f);
    check("tie_exclusive", both, 0);
    @(posedge i_Clk); #1;
    i_P1_Req = 0;
    repeat (3) @(posedge i_Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data RAM.
- Shares the single RAM access port between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Registers the winning request, drives RAM address, write-enable, byte-enables and write data, and waits out the RAM's one-cycle registered read.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- ADDR_WIDTH, 16, width of requester and RAM address buses (word address, passed through unmodified).

Ports:
- i_Clk  input  1  system clock; all state changes on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_P0_Req  input  1  port 0 request; held high with controls stable until o_P0_Ack.
- i_P0_Addr  input  ADDR_WIDTH  port 0 word address.
- i_P0_WE  input  1  port 0 write (1) / read (0).
- i_P0_ByteEn  input  4  port 0 byte lanes for writes.
- i_P0_WD  input  32  port 0 write data.
- o_P0_Ack  output  1  one-cycle completion pulse for port 0.
- o_P0_RD  output  32  port 0 read data; valid while o_P0_Ack is high for a read.
- i_P1_Req, i_P1_Addr, i_P1_WE, i_P1_ByteEn, i_P1_WD, o_P1_Ack, o_P1_RD  same as port 0, for port 1.
- o_Mem_Addr  output  ADDR_WIDTH  RAM address.
- o_Mem_WE  output  1  RAM write enable.
- o_Mem_ByteEn  output  4  RAM byte enables.
- o_Mem_WD  output  32  RAM write data.
- i_Mem_RD  input  32  RAM read data; registered, valid the cycle after address is presented.

Behaviour:
- Clock and reset: one clock, i_Clk. i_Rst is synchronous and active-high.
- Reset values: FSM = IDLE; o_P0_Ack = o_P1_Ack = 0; o_P0_RD = o_P1_RD = 0; o_Mem_Addr = 0; o_Mem_WE = 0; o_Mem_ByteEn = 0; o_Mem_WD = 0; grant owner = 0; last-grant pointer = 1.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, ACCESS, RDATA, DONE.
- IDLE:
  - Samples i_Px_Req.
  - No request: stay in IDLE, RAM controls held at 0.
  - Request present: latch winner's Addr/WE/ByteEn/WD into o_Mem_*, record owner, go to ACCESS.
  - o_Mem_WE = 0 and o_Mem_ByteEn = 0 in every state except ACCESS.
- ACCESS:
  - RAM sees registered controls for exactly one cycle.
  - Write: go to DONE, assert owner's Ack.
  - Read: go to RDATA.
  - Leaving ACCESS: clear o_Mem_WE and o_Mem_ByteEn.
- RDATA:
  - i_Mem_RD is valid.
  - Capture it into owner's o_Px_RD, assert owner's Ack, go to DONE.
- DONE:
  - Ack high for this one cycle only; requests are not sampled.
  - Go to IDLE, Ack returns to 0.
- Latency, req seen in IDLE cycle N:
  - write ack in cycle N+2.
  - read ack with data in cycle N+3.
  - Back-to-back transactions from one port are spaced by at least 1 IDLE cycle.
- Handshake rules:
  - Requester may change or drop its request on the edge ending its Ack cycle.
  - A request held high after Ack is treated as a new transaction at the next IDLE.
  - Dropping Req before Ack is illegal; the latched transaction completes regardless.
- Non-owner o_Px_RD holds its previous value; non-owner Ack stays 0.
- Simultaneous requests in IDLE: arbitration per Optional Feature; exactly one grant.
- Write with ByteEn = 0: still sequenced and acked; RAM contents unchanged.
- Addresses outside the RAM block: passed through unchanged; read data is whatever i_Mem_RD presents.
- Reset during ACCESS/RDATA/DONE: next state IDLE, pending Ack suppressed, in-flight write is not guaranteed to occur.
- Last-grant pointer updates on every grant, in both builds.

Optional Feature:
- Macro DRAM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant the port not equal to the last-grant pointer. Pointer resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority; port 0 always wins ties. Port 1 is served only when port 0 is idle in IDLE.

Test Plan:
- Reset then P0 read addr 2 (RAM word 0x6c6c6548) -> o_Mem_Addr = 2 for one cycle; o_P0_Ack pulses 3 cycles after req with o_P0_RD = 32'h6c6c6548.
- P1 write addr 10, WD = 32'hDEADBEEF, ByteEn = 4'b1111 -> o_Mem_WE high one cycle, o_P1_Ack 2 cycles after req; P1 read addr 10 returns 32'hDEADBEEF.
- P0 write addr 10, WD = 32'h00000055, ByteEn = 4'b0001 over 32'hDEADBEEF -> subsequent read returns 32'hDEADBE55.
- P0 and P1 reads held high continuously:
  - With DRAM_ARB_ROUND_ROBIN_EN: ack order P0, P1, P0, P1.
  - Without: P0 only, and P1 never acks until P0 drops Req.
- i_Rst asserted during ACCESS of a P1 read -> no o_P1_Ack; all outputs at reset values the next cycle; FSM in IDLE.
- Write with ByteEn = 0 to addr 3 -> acked in 2 cycles; read of addr 3 still 32'h6f57206f.
